// File: rtl/timing_gen_if.sv
// Bundles the start/request inputs and beat/phase outputs of timing_gen.
// step_mode exists only when TIMING_SINGLE_STEP_EN is defined.
interface timing_gen_if;
    logic qd;
    logic short;
    logic long;
    logic stop;
`ifdef TIMING_SINGLE_STEP_EN
    logic step_mode;
`endif
    logic w1, w2, w3;
    logic t1, t2, t3;
    logic running;
    logic cycle_end;

    modport slave (
        input  qd, short, long, stop,
`ifdef TIMING_SINGLE_STEP_EN
        input  step_mode,
`endif
        output w1, w2, w3, t1, t2, t3, running, cycle_end
    );

    modport master (
        output qd, short, long, stop,
`ifdef TIMING_SINGLE_STEP_EN
        output step_mode,
`endif
        input  w1, w2, w3, t1, t2, t3, running, cycle_end
    );
endinterface

// File: rtl/timing_gen.sv
// Beat/phase timing generator for the hardwired controller: one-hot beats W1..W3, phases T1..T3.
// Optional single-step halting at machine-cycle end is enabled by TIMING_SINGLE_STEP_EN.
//
// state | meaning
// IDLE  | after reset, waiting for a qd press; pending beat is W1
// RUN   | sequencing phases and beats
// HALT  | stopped by stop (or step_mode); qd resumes at the pending beat
module timing_gen #(
    parameter int unsigned PHASE_CLKS = 1
) (
    input  logic        clk,
    input  logic        clr,
    timing_gen_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [2:0] W1   = 3'b001;
    localparam logic [2:0] W2   = 3'b010;
    localparam logic [2:0] W3   = 3'b100;
    localparam logic [2:0] T1   = 3'b001;
    localparam logic [2:0] T3   = 3'b100;
    localparam logic [3:0] LAST = 4'(PHASE_CLKS - 1);

    state_t     state_q, state_d;
    logic [2:0] beat_q, beat_d;
    logic [2:0] phase_q, phase_d;
    logic [2:0] pend_q, pend_d;
    logic [3:0] cnt_q, cnt_d;
    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       sync3_q, sync3_d;

    logic       go;
    logic       beat_end;
    logic       halt;
    logic [2:0] next_beat;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            beat_q  <= 3'b000;
            phase_q <= 3'b000;
            pend_q  <= W1;
            cnt_q   <= 4'd0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            phase_q <= phase_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sync3_q <= sync3_d;
        end
    end

    always_comb begin
        sync1_d  = bus.qd;
        sync2_d  = sync1_q;
        sync3_d  = sync2_q;
        go       = sync2_q & ~sync3_q;
        beat_end = (phase_q == T3) && (cnt_q == LAST);

        case (beat_q)
            W1:      next_beat = bus.short ? W1 : W2;
            W2:      next_beat = bus.long ? W3 : W1;
            default: next_beat = W1;
        endcase

`ifdef TIMING_SINGLE_STEP_EN
        halt = bus.stop | (bus.step_mode & (next_beat == W1));
`else
        halt = bus.stop;
`endif

        state_d = state_q;
        beat_d  = beat_q;
        phase_d = phase_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE, HALT: begin
                if (go) begin
                    state_d = RUN;
                    beat_d  = pend_q;
                    phase_d = T1;
                    cnt_d   = 4'd0;
                end
            end
            RUN: begin
                if (beat_end) begin
                    cnt_d = 4'd0;
                    if (halt) begin
                        // w/t are flops, so clearing them here drops them on the halting edge
                        state_d = HALT;
                        pend_d  = next_beat;
                        beat_d  = 3'b000;
                        phase_d = 3'b000;
                    end else begin
                        beat_d  = next_beat;
                        phase_d = T1;
                    end
                end else if (cnt_q == LAST) begin
                    phase_d = {phase_q[1:0], 1'b0};
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = 3'b000;
                phase_d = 3'b000;
                pend_d  = W1;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign bus.w1        = beat_q[0];
    assign bus.w2        = beat_q[1];
    assign bus.w3        = beat_q[2];
    assign bus.t1        = phase_q[0];
    assign bus.t2        = phase_q[1];
    assign bus.t3        = phase_q[2];
    assign bus.running   = (state_q == RUN);
    assign bus.cycle_end = (state_q == RUN) && beat_end && (next_beat == W1);
endmodule
